// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared state encoding and sizing helpers for the SPI
// transmit scheduler and its shift core.
package spi_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_e;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int d);
      return $clog2(d + 1);
   endfunction

   function automatic int tmr_w(
      input int a,
      input int b,
      input int c,
      input int d
   );
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m + 1);
   endfunction

   // Lowest offset from ptr wins; scanning down lets it overwrite last.
   function automatic logic [7:0] rr_pick(
      input logic [7:0] valid,
      input logic [2:0] ptr,
      input int         n
   );
      logic [7:0] g;
      int         idx;
      g = '0;
      for (int k = n - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % n;
         if (valid[idx[2:0]]) g = 8'(1) << idx[2:0];
      end
      return g;
   endfunction

endpackage

// File: rtl/spi_tx_scheduler_if.sv
// spi_tx_scheduler_if: per-requester valid/ready/data bundle feeding
// the SPI transmit scheduler.
interface spi_tx_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready
   );
endinterface

// File: rtl/spi_shift_core.sv
// spi_shift_core: MSB-first CPOL=0/CPHA=0 serialiser with a per-phase
// clock divider; reports the cycle that ends the last sclk high phase.
module spi_shift_core
   import spi_sched_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = 1,
   parameter int CNT_W   = 5,
   parameter int TW      = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [DATA_W-1:0] word_i,
   input  logic              start_i,
   input  logic              clear_i,
   output logic              sclk_o,
   output logic              data_o,
   output logic [CNT_W-1:0]  counter_o,
   output logic              shift_done_o
);
   localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] sh_q;
   logic              sclk_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [TW-1:0]     div_q;
   logic              run_q;
   logic              tick;

   assign tick = run_q && (div_q == DIV_LAST);
   assign shift_done_o = tick && sclk_q
                         && (cnt_q == CNT_ONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_q   <= '0;
         sclk_q <= 1'b0;
         cnt_q  <= '0;
         div_q  <= '0;
         run_q  <= 1'b0;
      end else if (load_i) begin
         sh_q   <= word_i;
         sclk_q <= 1'b0;
         cnt_q  <= CNT_FULL;
         div_q  <= '0;
         run_q  <= 1'b0;
      end else if (start_i) begin
         run_q <= 1'b1;
         div_q <= '0;
      end else if (clear_i) begin
         sh_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (run_q) begin
         if (tick) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            // Falling edge: count the bit off, present the next one.
            if (sclk_q) begin
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) run_q <= 1'b0;
               else sh_q <= {sh_q[DATA_W-2:0], 1'b0};
            end
         end else begin
            div_q <= div_q + TW'(1);
         end
      end
   end

   assign sclk_o    = sclk_q;
   assign data_o    = sh_q[DATA_W-1];
   assign counter_o = cnt_q;
endmodule

// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler: round-robin arbiter sharing one SPI transmit channel;
// owns chip-select setup/hold and the inter-frame gap.
module spi_tx_scheduler
   import spi_sched_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 16,
   parameter int CLK_DIV  = 1,
   parameter int CS_SETUP = 1,
   parameter int CS_HOLD  = 1,
   parameter int GAP_CYC  = 2,
   localparam int GW = id_w(NUM_REQ),
   localparam int CW = cnt_w(DATA_W)
) (
   input  logic          clk,
   input  logic          reset,
   spi_tx_scheduler_if.slave req,
   output logic          spi_cs_L,
   output logic          spi_sclk,
   output logic          spi_data,
   output logic [CW-1:0] counter,
   output logic [GW-1:0] grant_id,
   output logic          busy,
   output logic          frame_done
);
   localparam int N  = NUM_REQ;
   localparam int TW = tmr_w(CLK_DIV, CS_SETUP,
                             CS_HOLD, GAP_CYC);
   localparam logic [TW-1:0] SETUP_LAST =
      TW'(CS_SETUP - 1);
   localparam logic [TW-1:0] HOLD_LAST =
      TW'(CS_HOLD - 1);
   // The accepting IDLE cycle is the final cs-high cycle of the gap.
   localparam logic [TW-1:0] GAP_LAST =
      TW'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);
   localparam logic [GW-1:0] LAST_ID = GW'(N - 1);

   state_e            state_q;
   logic [TW-1:0]     tmr_q;
   logic [GW-1:0]     ptr_q;
   logic [GW-1:0]     grant_q;
   logic              cs_q;
   logic              busy_q;
   logic              done_q;

   logic [N-1:0]      ready;
   logic              accept;
   logic [GW-1:0]     sel_idx;
   logic [DATA_W-1:0] sel_word;
   logic              start;
   logic              clear;
   logic              shift_done;

   assign ready = (state_q == IDLE)
      ? N'(rr_pick(8'(req.req_valid), 3'(ptr_q), N))
      : '0;
   assign req.req_ready = ready;
   assign accept = |ready;

   always_comb begin
      sel_idx  = '0;
      sel_word = '0;
      for (int i = 0; i < N; i++) begin
         if (ready[i]) begin
            sel_idx  = GW'(i);
            sel_word = req.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign start = (state_q == SETUP)
                  && (tmr_q == SETUP_LAST);
   assign clear = (state_q == HOLD)
                  && (tmr_q == HOLD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         ptr_q   <= '0;
         grant_q <= '0;
         cs_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (accept) begin
               state_q <= SETUP;
               tmr_q   <= '0;
               grant_q <= sel_idx;
               ptr_q   <= (sel_idx == LAST_ID)
                          ? '0 : sel_idx + GW'(1);
               cs_q    <= 1'b0;
               busy_q  <= 1'b1;
            end
            SETUP: begin
               if (start) begin
                  state_q <= SHIFT;
                  tmr_q   <= '0;
               end else begin
                  tmr_q <= tmr_q + TW'(1);
               end
            end
            SHIFT: if (shift_done) begin
               state_q <= HOLD;
               tmr_q   <= '0;
               done_q  <= (HOLD_LAST == '0);
            end
            HOLD: begin
               if (clear) begin
                  done_q <= 1'b0;
                  cs_q   <= 1'b1;
                  tmr_q  <= '0;
                  if (GAP_CYC > 1) begin
                     state_q <= GAP;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  tmr_q  <= tmr_q + TW'(1);
                  done_q <= (tmr_q + TW'(1) == HOLD_LAST);
               end
            end
            GAP: begin
               if (tmr_q == GAP_LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  tmr_q <= tmr_q + TW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   spi_shift_core #(
      .DATA_W (DATA_W),
      .CLK_DIV(CLK_DIV),
      .CNT_W  (CW),
      .TW     (TW)
   ) u_core (
      .clk         (clk),
      .reset       (reset),
      .load_i      (accept),
      .word_i      (sel_word),
      .start_i     (start),
      .clear_i     (clear),
      .sclk_o      (spi_sclk),
      .data_o      (spi_data),
      .counter_o   (counter),
      .shift_done_o(shift_done)
   );

   assign spi_cs_L   = cs_q;
   assign grant_id   = grant_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
endmodule

// File: tb/tb_spi_tx_scheduler.sv
// tb_spi_tx_scheduler: directed frame checks on a CLK_DIV=1 and a
// CLK_DIV=3 instance, table-driven arbitration sequence.
module tb_spi_tx_scheduler;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   spi_tx_scheduler_if #(.NUM_REQ(4), .DATA_W(16)) bus1();
   spi_tx_scheduler_if #(.NUM_REQ(4), .DATA_W(16)) bus3();

   logic       cs1, sclk1, dat1, busy1, fd1;
   logic       cs3, sclk3, dat3, busy3, fd3;
   logic [4:0] cnt1, cnt3;
   logic [1:0] gid1, gid3;

   spi_tx_scheduler dut1 (
      .clk(clk), .reset(reset), .req(bus1.slave),
      .spi_cs_L(cs1), .spi_sclk(sclk1),
      .spi_data(dat1), .counter(cnt1),
      .grant_id(gid1), .busy(busy1),
      .frame_done(fd1)
   );

   spi_tx_scheduler #(.CLK_DIV(3)) dut3 (
      .clk(clk), .reset(reset), .req(bus3.slave),
      .spi_cs_L(cs3), .spi_sclk(sclk3),
      .spi_data(dat3), .counter(cnt3),
      .grant_id(gid3), .busy(busy3),
      .frame_done(fd3)
   );

   bit         sel = 1'b0;
   logic       m_cs, m_sclk, m_dat, m_busy, m_fd;
   logic [4:0] m_cnt;
   logic [1:0] m_gid;
   logic [3:0] m_rdy;

   always_comb begin
      m_cs   = sel ? cs3 : cs1;
      m_sclk = sel ? sclk3 : sclk1;
      m_dat  = sel ? dat3 : dat1;
      m_busy = sel ? busy3 : busy1;
      m_fd   = sel ? fd3 : fd1;
      m_cnt  = sel ? cnt3 : cnt1;
      m_gid  = sel ? gid3 : gid1;
      m_rdy  = sel ? bus3.req_ready
                   : bus1.req_ready;
   end

   int checks = 0;
   int failures = 0;
   int last_acc = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
      end
   endtask

   task automatic set_valid(input bit w,
                            input logic [3:0] m);
      if (w) bus3.req_valid = m;
      else bus1.req_valid = m;
   endtask

   task automatic do_frame(input bit w,
                           input logic [3:0] mask,
                           input int eg,
                           input logic [15:0] word,
                           input bit chkp);
      int cdiv, t, lowc, rises, falls;
      int dcnt, dat_at, cerr, r1, r2;
      logic [15:0] cap;
      logic prev;
      cdiv = w ? 3 : 1;
      sel = w;
      set_valid(w, mask);
      #1;
      t = 0;
      while (m_rdy == 4'b0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (m_rdy == 4'b0) begin
         chk("accept_timeout", 32'(t), 32'(0));
         return;
      end
      chk("ready_onehot", 32'(m_rdy),
          32'(4'b0001 << eg));
      if (chkp) chk("accept_period",
                    32'(cyc - last_acc), 32'(36));
      last_acc = cyc;
      @(negedge clk);
      chk("ready_drop", 32'(m_rdy), 32'(0));
      chk("cs_fall", 32'(m_cs), 32'(0));
      chk("grant_id", 32'(m_gid), 32'(eg));
      chk("busy_frame", 32'(m_busy), 32'(1));
      chk("setup_cnt", 32'(m_cnt), 32'(16));
      chk("setup_msb", 32'(m_dat), 32'(word[15]));
      lowc = 0; rises = 0; falls = 0;
      dcnt = 0; dat_at = -1; cerr = 0;
      r1 = -1; r2 = -1;
      cap = '0; prev = 1'b0;
      while (m_cs == 1'b0 && lowc < 1000) begin
         lowc++;
         if (m_sclk && !prev) begin
            cap = {cap[14:0], m_dat};
            rises++;
            if (r1 < 0) r1 = lowc;
            else if (r2 < 0) r2 = lowc;
         end
         if (!m_sclk && prev) falls++;
         if (32'(m_cnt) != 32'(16 - falls)) cerr++;
         if (m_fd) begin
            dcnt++;
            dat_at = lowc;
         end
         prev = m_sclk;
         @(negedge clk);
      end
      chk("cs_low_len", 32'(lowc),
          32'(2 + 32 * cdiv));
      chk("frame_word", 32'(cap), 32'(word));
      chk("rise_count", 32'(rises), 32'(16));
      chk("sclk_period", 32'(r2 - r1),
          32'(2 * cdiv));
      chk("counter_seq", 32'(cerr), 32'(0));
      chk("done_count", 32'(dcnt), 32'(1));
      chk("done_last", 32'(dat_at), 32'(lowc));
      chk("gap_data", 32'(m_dat), 32'(0));
      chk("gap_sclk", 32'(m_sclk), 32'(0));
   endtask

   typedef struct {
      logic [3:0] mask;
      int         eg;
      bit         per;
   } vec_t;

   vec_t tbl[13];
   logic [15:0] wset[4];

   initial begin
      int t, rises;
      logic prev;

      tbl[0]  = '{4'b1111, 0, 1'b0};
      tbl[1]  = '{4'b1111, 1, 1'b1};
      tbl[2]  = '{4'b1111, 2, 1'b1};
      tbl[3]  = '{4'b1111, 3, 1'b1};
      tbl[4]  = '{4'b1001, 0, 1'b1};
      tbl[5]  = '{4'b1000, 3, 1'b1};
      tbl[6]  = '{4'b1111, 0, 1'b1};
      tbl[7]  = '{4'b1111, 1, 1'b1};
      tbl[8]  = '{4'b1111, 2, 1'b1};
      tbl[9]  = '{4'b1111, 3, 1'b1};
      tbl[10] = '{4'b0010, 1, 1'b1};
      tbl[11] = '{4'b0010, 1, 1'b1};
      tbl[12] = '{4'b0010, 1, 1'b1};
      wset[0] = 16'hA569;
      wset[1] = 16'h2563;
      wset[2] = 16'h9B63;
      wset[3] = 16'h6A61;

      reset = 1'b1;
      bus1.req_valid = '0;
      bus1.req_data  = '0;
      bus3.req_valid = '0;
      bus3.req_data  = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_cs", 32'(cs1), 32'(1));
      chk("rst_sclk", 32'(sclk1), 32'(0));
      chk("rst_data", 32'(dat1), 32'(0));
      chk("rst_cnt", 32'(cnt1), 32'(0));
      chk("rst_gid", 32'(gid1), 32'(0));
      chk("rst_busy", 32'(busy1), 32'(0));
      chk("rst_done", 32'(fd1), 32'(0));
      chk("rst_cs3", 32'(cs3), 32'(1));
      reset = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(bus1.req_ready), 32'(0));

      bus1.req_data = {16'h0, 16'hA265,
                       16'h0, 16'h0};
      do_frame(1'b0, 4'b0100, 2, 16'hA265, 1'b0);
      bus1.req_valid = '0;
      repeat (4) @(negedge clk);
      chk("idle_busy", 32'(busy1), 32'(0));

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus1.req_data = {wset[3], wset[2],
                       wset[1], wset[0]};
      for (int i = 0; i < 13; i++)
         do_frame(1'b0, tbl[i].mask, tbl[i].eg,
                  wset[tbl[i].eg], tbl[i].per);
      bus1.req_valid = '0;
      repeat (4) @(negedge clk);

      bus1.req_valid = 4'b0010;
      #1;
      t = 0;
      while (bus1.req_ready == 4'b0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("mid_ready", 32'(bus1.req_ready),
          32'(4'b0010));
      rises = 0; prev = 1'b0; t = 0;
      while (rises < 10 && t < 200) begin
         @(negedge clk);
         t++;
         if (sclk1 && !prev) rises++;
         prev = sclk1;
      end
      chk("mid_rises", 32'(rises), 32'(10));
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_cs", 32'(cs1), 32'(1));
      chk("mid_rst_sclk", 32'(sclk1), 32'(0));
      chk("mid_rst_data", 32'(dat1), 32'(0));
      chk("mid_rst_busy", 32'(busy1), 32'(0));
      chk("mid_rst_cnt", 32'(cnt1), 32'(0));
      bus1.req_valid = 4'b0110;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      do_frame(1'b0, 4'b0110, 1, wset[1], 1'b0);
      bus1.req_valid = '0;

      bus3.req_data = {16'h0, 16'h0,
                       16'h0, 16'h7564};
      do_frame(1'b1, 4'b0001, 0, 16'h7564, 1'b0);
      bus3.req_valid = '0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule
